// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared types and helpers for the clock-divider configuration front-end.
//   - state_e       : IDLE / WAIT / SETTLE sequencing states
//   - div_w()       : ratio field width for a given maximum ratio
//   - div_legal_max : largest ratio representable and allowed
//   - div_legal()   : ratio range check (non-zero and not above max)
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // $clog2 of a ratio; never narrower than one bit so a degenerate
  // MAX_DIV_BY of 1 still yields a usable port.
  function automatic int div_w(input int max_div_by);
    return (max_div_by > 1) ? $clog2(max_div_by) : 1;
  endfunction

  // The field may be too narrow to hold MAX_DIV_BY itself (power-of-two
  // maxima), so the usable ceiling is the smaller of the two.
  function automatic int div_legal_max(input int max_div_by, input int w);
    return (max_div_by < (1 << w) - 1) ? max_div_by : (1 << w) - 1;
  endfunction

  function automatic logic div_legal(input int unsigned value, input int unsigned max);
    return (value != 0) && (value <= max);
  endfunction

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// clk_div_cfg_ctrl_if
//   Ratio-request handshake between a CSR/software master and the
//   configuration controller.
//   - req_valid_i : new-ratio request (master -> slave)
//   - req_div_i   : requested ratio   (master -> slave)
//   - req_ready_o : request accepted when high with valid (slave -> master)
interface clk_div_cfg_ctrl_if #(
  parameter int DIV_W = 2
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [DIV_W-1:0] req_div_i;

  modport master (output req_valid_i, output req_div_i, input  req_ready_o);
  modport slave  (input  req_valid_i, input  req_div_i, output req_ready_o);
endinterface

// File: rtl/clk_div_replica.sv
// clk_div_replica
//   Cycle-exact copy of the downstream divider's ratio/count registers, so
//   the controller knows where the divider is in its output period.
//   Ports:
//   - clk_in, rst_n : clock, async active-low reset
//   - conf_i        : the ratio being driven to the divider
//   - div_q, cnt_q  : replica of divider_r / cnt_r
//   - last_m1       : this edge is a safe commit edge (two before wrap, or
//                     every edge when the ratio is 1)
module clk_div_replica
  import clk_div_pkg::*;
#(
  parameter int DIV_W     = 2,
  parameter int RESET_DIV = 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] conf_i,
  output logic [DIV_W-1:0] div_q,
  output logic [DIV_W-1:0] cnt_q,
  output logic             last_m1
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(RESET_DIV);
      cnt_q <= '0;
    end else begin
      div_q <= conf_i;
      cnt_q <= (cnt_q == div_q - 1'b1) ? '0 : cnt_q + 1'b1;
    end
  end

  // Committing here puts the new conf on the divider input during the
  // wrap cycle, so divider_r switches exactly as cnt_r returns to 0.
  assign last_m1 = (div_q > DIV_W'(1)) ? (cnt_q == div_q - DIV_W'(2)) : 1'b1;

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl
//   Glitch-safe ratio update front-end for configurable_clock_divider_fpga.
//   Accepts a ratio over a valid/ready handshake and commits it to
//   divider_conf_o only on a period boundary of the downstream divider.
//   Ports:
//   - clk_in, rst_n    : clock (shared with divider), async active-low reset
//   - req (slave)      : req_valid_i / req_ready_o / req_div_i
//   - divider_conf_o   : drives the divider's divider_conf
//   - busy_o           : a change is in flight
//   - done_o           : one-cycle pulse, new ratio active downstream
//   - err_o            : one-cycle pulse, illegal request rejected
//   Build option CLK_DIV_CFG_RANGE_CHECK_EN:
//   - defined   : ratio 0 or above the legal max is rejected with err_o
//   - undefined : such ratios are clamped into range, err_o stays 0
module clk_div_cfg_ctrl
  import clk_div_pkg::*;
#(
  parameter  int          MAX_DIV_BY    = 3,
  parameter  int          RESET_DIV     = 1,
  localparam int          DIV_W         = div_w(MAX_DIV_BY),
  localparam int unsigned DIV_LEGAL_MAX = div_legal_max(MAX_DIV_BY, DIV_W)
) (
  input  logic              clk_in,
  input  logic              rst_n,
  clk_div_cfg_ctrl_if.slave req,
  output logic [DIV_W-1:0]  divider_conf_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e           state_q;
  logic [DIV_W-1:0] pend_q;
  logic [DIV_W-1:0] req_eff;
  logic             req_ok;
  logic [DIV_W-1:0] rep_div;
  logic [DIV_W-1:0] rep_cnt;
  logic             last_m1;

  clk_div_replica #(
    .DIV_W    (DIV_W),
    .RESET_DIV(RESET_DIV)
  ) u_replica (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .conf_i (divider_conf_o),
    .div_q  (rep_div),
    .cnt_q  (rep_cnt),
    .last_m1(last_m1)
  );

  always_comb begin
    req_eff = req.req_div_i;
    req_ok  = 1'b1;
`ifdef CLK_DIV_CFG_RANGE_CHECK_EN
    req_ok  = div_legal(32'(req.req_div_i), DIV_LEGAL_MAX);
`else
    if (req.req_div_i == '0)
      req_eff = DIV_W'(1);
    else if (32'(req.req_div_i) > DIV_LEGAL_MAX)
      req_eff = DIV_W'(DIV_LEGAL_MAX);
`endif
  end

  assign req.req_ready_o = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pend_q         <= DIV_W'(RESET_DIV);
      divider_conf_o <= DIV_W'(RESET_DIV);
      done_o         <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req.req_valid_i) begin
            if (req_ok) begin
              pend_q  <= req_eff;
              state_q <= WAIT;
            end else begin
              err_o   <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (last_m1) begin
            divider_conf_o <= pend_q;
            state_q        <= SETTLE;
          end
        end
        SETTLE: begin
          // Downstream picks up the new ratio on this edge.
          state_q <= IDLE;
          done_o  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // In SETTLE the divider must be in its last count, otherwise the commit
  // was mistimed and the divider would wrap through its full range.
  a_settle_at_wrap: assert property (
    @(posedge clk_in) disable iff (!rst_n)
    (state_q == SETTLE) |-> (rep_cnt == rep_div - 1'b1)
  );

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
module tb_clk_div_cfg_ctrl;

  localparam int MAX_DIV_BY = 3;
  localparam int RESET_DIV  = 1;
  localparam int DIV_W      = $clog2(MAX_DIV_BY);
  localparam int LMAX       = (MAX_DIV_BY < (1 << DIV_W) - 1) ? MAX_DIV_BY : (1 << DIV_W) - 1;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic [DIV_W-1:0] divider_conf_o;
  logic             busy_o, done_o, err_o;

  clk_div_cfg_ctrl_if #(.DIV_W(DIV_W)) req_if ();

  clk_div_cfg_ctrl #(
    .MAX_DIV_BY(MAX_DIV_BY),
    .RESET_DIV (RESET_DIV)
  ) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .req           (req_if.slave),
    .divider_conf_o(divider_conf_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk_in = ~clk_in;

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outcome of one accepted request.
  typedef struct {
    bit               is_err;
    int               acc;     // accept edge
    int               commit;  // edge where the new ratio reaches the divider input
    int               fin;     // edge after which done_o is high
    logic [DIV_W-1:0] conf;
  } exp_t;

  exp_t             q[$];
  logic [DIV_W-1:0] cur_conf = DIV_W'(RESET_DIV);  // active ratio (monitor side)
  int               sb_div   = RESET_DIV;          // ratio after all issued requests

  // Downstream divider model: counts edges per output period and reports the
  // length of each completed period together with the ratio it started with.
  logic [DIV_W-1:0] ds_div = DIV_W'(RESET_DIV);
  logic [DIV_W-1:0] ds_cnt = '0;
  int cyc = 0, plen = 0, pdiv = RESET_DIV, wlen = 0, wdiv = 0;
  bit wrapped = 1'b0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; ds_div <= DIV_W'(RESET_DIV); ds_cnt <= '0;
      plen <= 0; pdiv <= RESET_DIV; wrapped <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      ds_div <= divider_conf_o;
      if (ds_cnt == ds_div - 1'b1) begin
        ds_cnt  <= '0;
        wrapped <= 1'b1;
        wlen    <= plen + 1;
        wdiv    <= pdiv;
        plen    <= 0;
        pdiv    <= int'(divider_conf_o);
      end else begin
        ds_cnt  <= ds_cnt + 1'b1;
        plen    <= plen + 1;
        wrapped <= 1'b0;
      end
    end
  end

  // Edges after accept until the commit edge: the first edge at which the
  // divider count (before the edge) is ratio-2; every edge for ratio 1.
  function automatic int commit_k(input int d, input int c);
    if (d <= 1) return 1;
    for (int k = 1; k <= d; k++)
      if ((c + k) % d == d - 2) return k;
    return d;
  endfunction

  // Called at the negedge before the accepting edge.
  task automatic predict(input int d);
    exp_t e;
    int   nv;
    e.acc    = cyc + 1;
    e.is_err = 1'b0;
`ifdef CLK_DIV_CFG_RANGE_CHECK_EN
    if (d < 1 || d > LMAX) begin
      e.is_err = 1'b1;
      e.commit = e.acc;
      e.fin    = e.acc;
      e.conf   = DIV_W'(sb_div);
      q.push_back(e);
      return;
    end
    nv = d;
`else
    nv = (d < 1) ? 1 : (d > LMAX) ? LMAX : d;
`endif
    e.commit = e.acc + commit_k(sb_div, int'(ds_cnt));
    e.fin    = e.commit + 1;
    e.conf   = DIV_W'(nv);
    q.push_back(e);
    sb_div = nv;
  endtask

  // Must be called at a negedge; returns just after the accepting edge.
  task automatic send(input int d);
    int w = 0;
    req_if.req_valid_i = 1'b1;
    req_if.req_div_i   = DIV_W'(d);
    while (!req_if.req_ready_o && w < 40) begin
      @(negedge clk_in);
      w++;
    end
    if (!req_if.req_ready_o) check("accept_timeout", 0, 1);
    else                     predict(d);
    @(posedge clk_in);
    #1;
    req_if.req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk_in);
    while (q.size() > 0 && w < 200) begin
      @(negedge clk_in);
      w++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_phase(input int p);
    int w = 0;
    while (int'(ds_cnt) != p && w < 10) begin
      @(negedge clk_in);
      w++;
    end
    check("phase_reached", int'(ds_cnt), p);
  endtask

  // Monitor / scoreboard: checks every output each cycle and retires the
  // head expectation when its done/err pulse is due.
  always @(negedge clk_in) begin : mon
    bit               eb, ed, ee, hd;
    logic [DIV_W-1:0] ec;
    if (rst_n) begin
      hd = (q.size() > 0);
      eb = hd && !q[0].is_err && q[0].acc <= cyc && cyc < q[0].fin;
      ed = hd && !q[0].is_err && cyc == q[0].fin;
      ee = hd &&  q[0].is_err && cyc == q[0].acc;
      ec = (hd && !q[0].is_err && cyc >= q[0].commit) ? q[0].conf : cur_conf;
      check("busy_o",         int'(busy_o),            int'(eb));
      check("req_ready_o",    int'(req_if.req_ready_o), int'(!eb));
      check("divider_conf_o", int'(divider_conf_o),    int'(ec));
      check("done_o",         int'(done_o),            int'(ed));
      check("err_o",          int'(err_o),             int'(ee));
      check("replica_cnt",    int'(dut.u_replica.cnt_q), int'(ds_cnt));
      check("replica_div",    int'(dut.u_replica.div_q), int'(ds_div));
      if (wrapped) check("period_len", wlen, wdiv);
      if (ed) begin
        cur_conf = q[0].conf;
        void'(q.pop_front());
      end else if (ee) begin
        void'(q.pop_front());
      end
    end
  end

  initial begin : stim
    int c_edge, w;
    req_if.req_valid_i = 1'b0;
    req_if.req_div_i   = '0;

    // Reset values while held in reset
    repeat (3) @(negedge clk_in);
    check("rst_conf",  int'(divider_conf_o), RESET_DIV);
    check("rst_ready", int'(req_if.req_ready_o), 1);
    check("rst_busy",  int'(busy_o), 0);
    check("rst_done",  int'(done_o), 0);
    check("rst_err",   int'(err_o), 0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk_in);

    // 1 -> 3, then 3 -> 2 accepted with count at 2
    send(3);
    wait_idle();
    wait_phase(2);
    send(2);
    wait_idle();
    repeat (6) @(negedge clk_in);

    // From ratio 3, request 1 at each count phase
    for (int ph = 0; ph < 3; ph++) begin
      @(negedge clk_in);
      send(3);
      wait_idle();
      repeat (2) @(negedge clk_in);
      wait_phase(ph);
      send(1);
      wait_idle();
    end

    // Ratio 0: rejected or clamped depending on build
    @(negedge clk_in);
    send(0);
    wait_idle();
    repeat (3) @(negedge clk_in);

    // Back-to-back: 3 stalls behind 2
    send(2);
    @(negedge clk_in);
    send(3);
    wait_idle();
    check("b2b_final_conf", int'(divider_conf_o), 3);

    // Same ratio again still runs a full sequence
    @(negedge clk_in);
    send(3);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      repeat ($urandom_range(0, 3)) @(negedge clk_in);
      send(int'($urandom_range(0, (1 << DIV_W) - 1)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // Reset asserted during SETTLE aborts the change
    @(negedge clk_in);
    send(3);
    wait_idle();
    send(2);
    c_edge = q[$].commit;
    w = 0;
    @(negedge clk_in);
    while (cyc != c_edge && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    check("settle_reached", cyc, c_edge);
    #2 rst_n = 1'b0;
    #1;
    check("abort_conf",  int'(divider_conf_o), RESET_DIV);
    check("abort_busy",  int'(busy_o), 0);
    check("abort_ready", int'(req_if.req_ready_o), 1);
    check("abort_done",  int'(done_o), 0);
    q.delete();
    cur_conf = DIV_W'(RESET_DIV);
    sb_div   = RESET_DIV;
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk_in);

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
